// File: rtl/mem_access_stage.sv
// RV32I MEM stage: aligns loads and stores onto a valid/ack data port, extends load data,
// and presents one writeback result per instruction. Stalls upstream while an access is pending.
module mem_access_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_ex_valid,
    input  logic [31:0] i_ex_aluout,
    input  logic [31:0] i_ex_store_data,
    input  logic [4:0]  i_ex_rd,
    input  logic        i_ex_regwrite,
    input  logic        i_ex_memread,
    input  logic        i_ex_memwrite,
    input  logic [2:0]  i_ex_dmtype,
    input  logic        i_ex_link,
    input  logic [31:0] i_ex_pc,
    output logic        o_mem_stall,
    output logic        o_dmem_req,
    output logic        o_dmem_we,
    output logic [31:0] o_dmem_addr,
    output logic [31:0] o_dmem_wdata,
    output logic [3:0]  o_dmem_be,
    input  logic [31:0] i_dmem_rdata,
    input  logic        i_dmem_ack,
    output logic        o_wb_valid,
    output logic        o_wb_regwrite,
    output logic [4:0]  o_wb_rd,
    output logic [31:0] o_wb_data,
    output logic        o_misalign_exc,
    output logic        o_bus_err,
    output logic [31:0] o_fault_addr
);
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic {StIdle, StAccess} state_e;

    state_e        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_dmem_req, r_dmem_we;
    logic [31:0]   r_dmem_addr, r_dmem_wdata;
    logic [3:0]    r_dmem_be;
    logic          r_wb_valid, r_wb_regwrite, r_misalign, r_bus_err;
    logic [4:0]    r_wb_rd, r_rd;
    logic [31:0]   r_wb_data, r_fault_addr, r_addr;
    logic          r_regwrite;
    logic [2:0]    r_dmtype;

    logic          w_is_mem, w_misalign, w_regwrite;
    logic [3:0]    w_be;
    logic [31:0]   w_wdata, w_shift, w_load_data;

    assign w_is_mem   = i_ex_memread | i_ex_memwrite;
    assign w_regwrite = i_ex_regwrite & (i_ex_rd != 5'd0);

    always_comb begin
        w_misalign = 1'b0;
        w_be       = 4'b1111;
        w_wdata    = i_ex_store_data;
        case (i_ex_dmtype)
            3'b011, 3'b100: begin
                w_be    = 4'b0001 << i_ex_aluout[1:0];
                w_wdata = {4{i_ex_store_data[7:0]}};
            end
            3'b001, 3'b010: begin
                w_misalign = i_ex_aluout[0];
                w_be       = i_ex_aluout[1] ? 4'b1100 : 4'b0011;
                w_wdata    = {2{i_ex_store_data[15:0]}};
            end
            default: w_misalign = (i_ex_aluout[1:0] != 2'b00);
        endcase
    end

    // Bring the addressed lane(s) down to bit 0, then extend per access type.
    always_comb begin
        w_shift     = i_dmem_rdata >> {r_addr[1:0], 3'b000};
        w_load_data = w_shift;
        case (r_dmtype)
            3'b001:  w_load_data = {{16{w_shift[15]}}, w_shift[15:0]};
            3'b010:  w_load_data = {16'h0000, w_shift[15:0]};
            3'b011:  w_load_data = {{24{w_shift[7]}}, w_shift[7:0]};
            3'b100:  w_load_data = {24'h000000, w_shift[7:0]};
            default: w_load_data = w_shift;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state       <= StIdle;
            r_cnt         <= '0;
            r_dmem_req    <= 1'b0;
            r_dmem_we     <= 1'b0;
            r_dmem_addr   <= 32'h0;
            r_dmem_wdata  <= 32'h0;
            r_dmem_be     <= 4'h0;
            r_wb_valid    <= 1'b0;
            r_wb_regwrite <= 1'b0;
            r_wb_rd       <= 5'd0;
            r_wb_data     <= 32'h0;
            r_misalign    <= 1'b0;
            r_bus_err     <= 1'b0;
            r_fault_addr  <= 32'h0;
            r_rd          <= 5'd0;
            r_regwrite    <= 1'b0;
            r_dmtype      <= 3'b000;
            r_addr        <= 32'h0;
        end else begin
            r_wb_valid    <= 1'b0;
            r_wb_regwrite <= 1'b0;
            r_misalign    <= 1'b0;
            r_bus_err     <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (i_ex_valid) begin
                        r_wb_rd <= i_ex_rd;
                        if (!w_is_mem) begin
                            r_wb_valid    <= 1'b1;
                            r_wb_regwrite <= w_regwrite;
                            r_wb_data     <= i_ex_link ? i_ex_pc + 32'd4 : i_ex_aluout;
                        end else if (w_misalign) begin
                            r_wb_valid   <= 1'b1;
                            r_wb_data    <= 32'h0;
                            r_misalign   <= 1'b1;
                            r_fault_addr <= i_ex_aluout;
                        end else begin
                            r_state      <= StAccess;
                            r_cnt        <= '0;
                            r_dmem_req   <= 1'b1;
                            r_dmem_we    <= i_ex_memwrite;
                            r_dmem_addr  <= {i_ex_aluout[31:2], 2'b00};
                            r_dmem_be    <= i_ex_memwrite ? w_be : 4'b1111;
                            r_dmem_wdata <= i_ex_memwrite ? w_wdata : 32'h0;
                            r_rd         <= i_ex_rd;
                            r_regwrite   <= w_regwrite & ~i_ex_memwrite;
                            r_dmtype     <= i_ex_dmtype;
                            r_addr       <= i_ex_aluout;
                        end
                    end
                end
                StAccess: begin
                    if (i_dmem_ack) begin
                        r_state       <= StIdle;
                        r_dmem_req    <= 1'b0;
                        r_dmem_we     <= 1'b0;
                        r_wb_valid    <= 1'b1;
                        r_wb_rd       <= r_rd;
                        r_wb_regwrite <= r_regwrite;
                        if (!r_dmem_we) r_wb_data <= w_load_data;
                    end else if (r_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                        r_state      <= StIdle;
                        r_dmem_req   <= 1'b0;
                        r_dmem_we    <= 1'b0;
                        r_bus_err    <= 1'b1;
                        r_fault_addr <= r_addr;
                        r_wb_valid   <= 1'b1;
                        r_wb_rd      <= r_rd;
                        r_wb_data    <= 32'h0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign o_mem_stall    = (r_state == StAccess);
    assign o_dmem_req     = r_dmem_req;
    assign o_dmem_we      = r_dmem_we;
    assign o_dmem_addr    = r_dmem_addr;
    assign o_dmem_wdata   = r_dmem_wdata;
    assign o_dmem_be      = r_dmem_be;
    assign o_wb_valid     = r_wb_valid;
    assign o_wb_regwrite  = r_wb_regwrite;
    assign o_wb_rd        = r_wb_rd;
    assign o_wb_data      = r_wb_data;
    assign o_misalign_exc = r_misalign;
    assign o_bus_err      = r_bus_err;
    assign o_fault_addr   = r_fault_addr;
endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: expected writeback results are queued when an
// instruction is issued and checked by a monitor whenever the stage reports a completion.
module tb_mem_access_stage;
    logic        clk = 1'b0;
    logic        reset;
    logic        ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_link;
    logic [31:0] ex_aluout, ex_store_data, ex_pc;
    logic [4:0]  ex_rd;
    logic [2:0]  ex_dmtype;
    logic        mem_stall, dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic        wb_valid, wb_regwrite, misalign_exc, bus_err;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data, fault_addr;

    typedef struct {
        logic        rw;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        chk_data;
        logic        mis;
        logic        berr;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    mem_access_stage #(.TIMEOUT_CYCLES(4)) dut (
        .i_clk(clk), .i_reset(reset), .i_ex_valid(ex_valid), .i_ex_aluout(ex_aluout),
        .i_ex_store_data(ex_store_data), .i_ex_rd(ex_rd), .i_ex_regwrite(ex_regwrite),
        .i_ex_memread(ex_memread), .i_ex_memwrite(ex_memwrite), .i_ex_dmtype(ex_dmtype),
        .i_ex_link(ex_link), .i_ex_pc(ex_pc), .o_mem_stall(mem_stall), .o_dmem_req(dmem_req),
        .o_dmem_we(dmem_we), .o_dmem_addr(dmem_addr), .o_dmem_wdata(dmem_wdata),
        .o_dmem_be(dmem_be), .i_dmem_rdata(dmem_rdata), .i_dmem_ack(dmem_ack),
        .o_wb_valid(wb_valid), .o_wb_regwrite(wb_regwrite), .o_wb_rd(wb_rd),
        .o_wb_data(wb_data), .o_misalign_exc(misalign_exc), .o_bus_err(bus_err),
        .o_fault_addr(fault_addr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic expect_wb(input logic rw, input logic [4:0] rd, input logic [31:0] data,
                             input logic chk_data, input logic mis, input logic berr);
        exp_t t;
        t.rw = rw; t.rd = rd; t.data = data; t.chk_data = chk_data; t.mis = mis; t.berr = berr;
        q.push_back(t);
    endtask

    // Completion monitor, sampling on the falling edge.
    always @(negedge clk) begin
        if (!reset) begin
            if (wb_valid) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $error("FAIL wb_unexpected observed=wb_valid expected=no completion");
                end else begin
                    mon_e = q.pop_front();
                    chk("wb_regwrite", 32'(wb_regwrite), 32'(mon_e.rw));
                    chk("wb_rd", 32'(wb_rd), 32'(mon_e.rd));
                    if (mon_e.chk_data) chk("wb_data", wb_data, mon_e.data);
                    chk("misalign_exc", 32'(misalign_exc), 32'(mon_e.mis));
                    chk("bus_err", 32'(bus_err), 32'(mon_e.berr));
                end
            end else begin
                chk("idle_pulses", 32'({misalign_exc, bus_err, wb_regwrite}), 32'h0);
            end
        end
    end

    task automatic issue(input logic [31:0] addr, input logic [31:0] sdata, input logic rd_en,
                         input logic wr_en, input logic [2:0] dt, input logic [4:0] rd);
        ex_aluout = addr; ex_store_data = sdata; ex_memread = rd_en; ex_memwrite = wr_en;
        ex_dmtype = dt; ex_rd = rd; ex_regwrite = 1'b1; ex_link = 1'b0; ex_valid = 1'b1;
        @(posedge clk); #1;
        ex_valid = 1'b0;
    endtask

    // Issue a memory op, ack in ACCESS cycle ack_at (0 = never), record what the port showed.
    task automatic mem_op(input logic [31:0] addr, input logic [31:0] sdata, input logic rd_en,
                          input logic wr_en, input logic [2:0] dt, input logic [4:0] rd,
                          input int ack_at, input logic [31:0] rdata, output int stalls,
                          output logic [31:0] a, output logic [3:0] be, output logic [31:0] wd,
                          output logic we, output int unstable);
        issue(addr, sdata, rd_en, wr_en, dt, rd);
        stalls = 0; unstable = 0;
        a = dmem_addr; be = dmem_be; wd = dmem_wdata; we = dmem_we;
        for (int c = 1; c <= 10; c++) begin
            if (!mem_stall) break;
            stalls++;
            if (!dmem_req || dmem_addr !== a || dmem_be !== be || dmem_wdata !== wd ||
                dmem_we !== we) unstable++;
            if (c == ack_at) begin
                dmem_ack = 1'b1; dmem_rdata = rdata;
            end
            @(posedge clk); #1;
            dmem_ack = 1'b0; dmem_rdata = 32'hDEAD_BEEF;
        end
    endtask

    int          st, un;
    logic [31:0] a, wd;
    logic [3:0]  be;
    logic        we;

    initial begin
        reset = 1'b1; ex_valid = 1'b0; ex_aluout = 0; ex_store_data = 0; ex_rd = 0;
        ex_regwrite = 0; ex_memread = 0; ex_memwrite = 0; ex_dmtype = 0; ex_link = 0;
        ex_pc = 0; dmem_ack = 0; dmem_rdata = 32'hDEAD_BEEF;
        #2;
        chk("rst_ctl", 32'({mem_stall, dmem_req, dmem_we, dmem_be, wb_valid, wb_regwrite,
                            misalign_exc, bus_err, wb_rd}), 32'h0);
        chk("rst_addr", dmem_addr | dmem_wdata, 32'h0);
        chk("rst_wb_data", wb_data, 32'h0);
        chk("rst_fault", fault_addr, 32'h0);
        @(posedge clk); #1; reset = 1'b0;

        // ALU pass-through, latency 1
        expect_wb(1'b1, 5'd5, 32'h1234, 1'b1, 1'b0, 1'b0);
        issue(32'h1234, 32'h0, 1'b0, 1'b0, 3'b000, 5'd5);
        chk("alu_stall", 32'(mem_stall), 32'h0);
        chk("alu_wbv", 32'(wb_valid), 32'h1);
        // Link writes PC+4
        ex_pc = 32'h1000; ex_link = 1'b1; ex_aluout = 32'h5555; ex_rd = 5'd1; ex_valid = 1'b1;
        ex_memread = 0; ex_memwrite = 0;
        expect_wb(1'b1, 5'd1, 32'h1004, 1'b1, 1'b0, 1'b0);
        @(posedge clk); #1; ex_valid = 1'b0; ex_link = 1'b0;
        // rd = x0 suppresses regwrite
        expect_wb(1'b0, 5'd0, 32'h77, 1'b1, 1'b0, 1'b0);
        issue(32'h77, 32'h0, 1'b0, 1'b0, 3'b000, 5'd0);

        // lb sign / lbu zero, ack in 3rd ACCESS cycle
        expect_wb(1'b1, 5'd7, 32'hFFFF_FF80, 1'b1, 1'b0, 1'b0);
        mem_op(32'h103, 0, 1, 0, 3'b011, 5'd7, 3, 32'h80FF_FF00, st, a, be, wd, we, un);
        chk("lb_stalls", 32'(st), 32'd3);
        chk("lb_addr", a, 32'h100);
        chk("lb_be_we", 32'({be, we}), 32'({4'b1111, 1'b0}));
        chk("lb_stable", 32'(un), 32'd0);
        chk("lb_req_drop", 32'({dmem_req, mem_stall}), 32'h0);
        expect_wb(1'b1, 5'd7, 32'h0000_0080, 1'b1, 1'b0, 1'b0);
        mem_op(32'h103, 0, 1, 0, 3'b100, 5'd7, 3, 32'h80FF_FF00, st, a, be, wd, we, un);
        chk("lbu_stalls", 32'(st), 32'd3);

        // sh upper half, minimum latency
        expect_wb(1'b0, 5'd9, 32'h0, 1'b0, 1'b0, 1'b0);
        mem_op(32'h202, 32'hAAAA_BEEF, 0, 1, 3'b001, 5'd9, 1, 32'h0, st, a, be, wd, we, un);
        chk("sh_be", 32'(be), 32'(4'b1100));
        chk("sh_wdata", wd, 32'hBEEF_BEEF);
        chk("sh_we", 32'(we), 32'h1);
        chk("sh_addr", a, 32'h200);
        chk("sh_stalls", 32'(st), 32'd1);
        // sb lane 1
        expect_wb(1'b0, 5'd4, 32'h0, 1'b0, 1'b0, 1'b0);
        mem_op(32'h101, 32'h1234_5678, 0, 1, 3'b011, 5'd4, 2, 32'h0, st, a, be, wd, we, un);
        chk("sb_be", 32'(be), 32'(4'b0010));
        chk("sb_wdata", wd, 32'h7878_7878);
        chk("sb_stable", 32'(un), 32'd0);

        // Misaligned lw
        expect_wb(1'b0, 5'd6, 32'h0, 1'b0, 1'b1, 1'b0);
        issue(32'h301, 32'h0, 1'b1, 1'b0, 3'b000, 5'd6);
        chk("mis_req", 32'({dmem_req, mem_stall}), 32'h0);
        chk("mis_fault", fault_addr, 32'h301);
        // Misaligned lh at odd address
        expect_wb(1'b0, 5'd6, 32'h0, 1'b0, 1'b1, 1'b0);
        issue(32'h305, 32'h0, 1'b1, 1'b0, 3'b001, 5'd6);
        chk("mish_fault", fault_addr, 32'h305);

        // Ack in IDLE is ignored
        dmem_ack = 1'b1; @(posedge clk); #1; dmem_ack = 1'b0;
        chk("idle_ack", 32'({mem_stall, dmem_req, wb_valid}), 32'h0);

        // Timeout after 4 ACCESS cycles
        expect_wb(1'b0, 5'd3, 32'h0, 1'b0, 1'b0, 1'b1);
        mem_op(32'h400, 0, 1, 0, 3'b000, 5'd3, 0, 32'h0, st, a, be, wd, we, un);
        chk("to_stalls", 32'(st), 32'd4);
        chk("to_fault", fault_addr, 32'h400);
        chk("to_req", 32'(dmem_req), 32'h0);
        // Ack on the limit cycle wins
        expect_wb(1'b1, 5'd3, 32'hCAFE_F00D, 1'b1, 1'b0, 1'b0);
        mem_op(32'h404, 0, 1, 0, 3'b000, 5'd3, 4, 32'hCAFE_F00D, st, a, be, wd, we, un);
        chk("ack4_stalls", 32'(st), 32'd4);

        // Reset mid-ACCESS abandons the access
        issue(32'h500, 32'h0, 1'b1, 1'b0, 3'b000, 5'd2);
        chk("rm_stall", 32'({mem_stall, dmem_req}), 32'h3);
        #2; reset = 1'b1; #1;
        chk("rm_async", 32'({mem_stall, dmem_req}), 32'h0);
        @(posedge clk); #1; reset = 1'b0;
        chk("rm_fault", fault_addr, 32'h0);
        expect_wb(1'b1, 5'd8, 32'h0000_8001, 1'b1, 1'b0, 1'b0);
        mem_op(32'h602, 0, 1, 0, 3'b010, 5'd8, 2, 32'h8001_0000, st, a, be, wd, we, un);
        chk("rm_after", 32'(st), 32'd2);

        repeat (3) @(posedge clk);
        #1;
        chk("queue_empty", 32'(q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
